// File: rtl/operand_entry_fsm.sv
// Input stage for the signed alien calculator: debounces ENTER/CLEAR and captures
// operand A, operand B and the one-hot operation mode in sequence.
module operand_entry_fsm #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sw,
    input  logic       btn_enter,
    input  logic       btn_clear,
    output logic [4:0] portA,
    output logic [4:0] portB,
    output logic [5:0] MODE,
    output logic [1:0] stage,
    output logic       valid,
    output logic       mode_err
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_B     = 2'd1,
        S_MODE  = 2'd2,
        S_READY = 2'd3
    } state_t;

    // Index 0 = ENTER, index 1 = CLEAR.
    logic [1:0]    btn_raw;
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    db_q, db_d, db_prev_q;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic          enter_pulse, clear_pulse;

    assign btn_raw = {btn_clear, btn_enter};

    // The counter only runs while the synced level disagrees with the accepted
    // level; any bounce back to agreement restarts the qualification window.
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            for (int unsigned i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            for (int unsigned i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign enter_pulse = db_q[0] & ~db_prev_q[0];
    assign clear_pulse = db_q[1] & ~db_prev_q[1];

    function automatic logic [4:0] norm(input logic [4:0] v);
        return (v == 5'b10000) ? 5'b00000 : v;
    endfunction

    state_t     state_q, state_d;
    logic [4:0] port_a_q, port_a_d;
    logic [4:0] port_b_q, port_b_d;
    logic [5:0] mode_q, mode_d;
    logic       valid_q, valid_d;
    logic       mode_err_q, mode_err_d;

    always_comb begin
        state_d    = state_q;
        port_a_d   = port_a_q;
        port_b_d   = port_b_q;
        mode_d     = mode_q;
        valid_d    = valid_q;
        mode_err_d = mode_err_q;
        if (clear_pulse) begin
            state_d    = S_A;
            port_a_d   = '0;
            port_b_d   = '0;
            mode_d     = '0;
            valid_d    = 1'b0;
            mode_err_d = 1'b0;
        end else if (enter_pulse) begin
            unique case (state_q)
                S_A: begin
                    port_a_d   = norm(sw[4:0]);
                    valid_d    = 1'b0;
                    mode_err_d = 1'b0;
                    state_d    = S_B;
                end
                S_B: begin
                    port_b_d = norm(sw[4:0]);
                    state_d  = S_MODE;
                end
                S_MODE: begin
                    if ($onehot(sw)) begin
                        mode_d     = sw;
                        valid_d    = 1'b1;
                        mode_err_d = 1'b0;
                        state_d    = S_READY;
                    end else begin
                        mode_err_d = 1'b1;
                    end
                end
                S_READY: begin
                    valid_d = 1'b0;
                    state_d = S_A;
                end
                default: state_d = S_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_A;
            port_a_q   <= '0;
            port_b_q   <= '0;
            mode_q     <= '0;
            valid_q    <= 1'b0;
            mode_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            port_a_q   <= port_a_d;
            port_b_q   <= port_b_d;
            mode_q     <= mode_d;
            valid_q    <= valid_d;
            mode_err_q <= mode_err_d;
        end
    end

    assign portA    = port_a_q;
    assign portB    = port_b_q;
    assign MODE     = mode_q;
    assign stage    = state_q;
    assign valid    = valid_q;
    assign mode_err = mode_err_q;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Bench for operand_entry_fsm with a short debounce window: transaction-level model
// checked every settled cycle, plus directed literal expectations.
module tb_operand_entry_fsm;

    localparam int unsigned DB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] sw;
    logic       btn_enter, btn_clear;
    logic [4:0] portA, portB;
    logic [5:0] MODE;
    logic [1:0] stage;
    logic       valid, mode_err;

    always #5 clk = ~clk;

    operand_entry_fsm #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .sw(sw), .btn_enter(btn_enter), .btn_clear(btn_clear),
        .portA(portA), .portB(portB), .MODE(MODE), .stage(stage),
        .valid(valid), .mode_err(mode_err)
    );

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    bit          check_en = 1'b0;

    // Transaction-level model of the captured registers.
    logic [4:0] m_a, m_b;
    logic [5:0] m_mode;
    int         m_stage;
    logic       m_valid, m_err;

    function automatic void m_reset();
        m_a = 0; m_b = 0; m_mode = 0; m_stage = 0; m_valid = 0; m_err = 0;
    endfunction

    function automatic void m_enter(input logic [5:0] s);
        logic [4:0] v;
        v = (s[4:0] == 5'b10000) ? 5'b00000 : s[4:0];
        if (m_stage == 0) begin
            m_a = v; m_valid = 0; m_err = 0; m_stage = 1;
        end else if (m_stage == 1) begin
            m_b = v; m_stage = 2;
        end else if (m_stage == 2) begin
            if ($countones(s) == 1) begin
                m_mode = s; m_valid = 1; m_err = 0; m_stage = 3;
            end else begin
                m_err = 1;
            end
        end else begin
            m_valid = 0; m_stage = 0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (check_en)
            check("model", {12'h0, portA, portB, MODE, stage, valid, mode_err},
                  {12'h0, m_a, m_b, m_mode, 2'(m_stage), m_valid, m_err});
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input logic [5:0] s, input bit en, input bit cl);
        check_en = 1'b0;
        sw = s; btn_enter = en; btn_clear = cl;
        cyc(12);
        btn_enter = 1'b0; btn_clear = 1'b0;
        cyc(12);
        if (cl) m_reset();
        else if (en) m_enter(s);
        check_en = 1'b1;
        cyc(2);
    endtask

    initial begin
        sw = '0; btn_enter = 1'b0; btn_clear = 1'b0; rst = 1'b1;
        m_reset();
        cyc(3);
        check("reset_state", {12'h0, portA, portB, MODE, stage, valid, mode_err}, 32'h0);
        rst = 1'b0;
        check_en = 1'b1;
        cyc(2);

        // Three clean captures.
        press(6'b001011, 1, 0);
        press(6'b010110, 1, 0);
        press(6'b000100, 1, 0);
        check("t1_portA", portA, 32'h0B);
        check("t1_portB", portB, 32'h16);
        check("t1_MODE", MODE, 32'h04);
        check("t1_valid", valid, 32'h1);
        check("t1_stage", stage, 32'h3);

        // Invalid mode entries, then a valid one.
        press(6'b000000, 1, 0);
        press(6'b001011, 1, 0);
        press(6'b000011, 1, 0);
        press(6'b000110, 1, 0);
        check("t3_err_two_bits", mode_err, 32'h1);
        check("t3_stage_hold", stage, 32'h2);
        check("t3_mode_hold", MODE, 32'h04);
        press(6'b000000, 1, 0);
        check("t3_err_zero", mode_err, 32'h1);
        press(6'b100000, 1, 0);
        check("t3_mode_new", MODE, 32'h20);
        check("t3_err_cleared", mode_err, 32'h0);
        check("t3_valid", valid, 32'h1);

        // Negative zero normalisation.
        press(6'b000000, 1, 0);
        press(6'b010000, 1, 0);
        check("t4_negzero", portA, 32'h00);
        check("t4_stage", stage, 32'h1);

        // Clear, recapture A, then ENTER and CLEAR debounced in the same cycle.
        press(6'b000000, 0, 1);
        check("clear_stage", stage, 32'h0);
        press(6'b000101, 1, 0);
        check("t5_pre_portA", portA, 32'h05);
        press(6'b001111, 1, 1);
        check("t5_all_zero", {12'h0, portA, portB, MODE, stage, valid, mode_err}, 32'h0);
        check("t5_portB", portB, 32'h0);

        // Glitchy ENTER: only the steady level qualifies, 7 cycles after it starts.
        check_en = 1'b0;
        sw = 6'b000110;
        btn_enter = 1'b1; cyc(2);
        btn_enter = 1'b0; cyc(2);
        btn_enter = 1'b1; cyc(1);
        btn_enter = 1'b0; cyc(2);
        btn_enter = 1'b1; cyc(6);
        check("t2_before_pulse", stage, 32'h0);
        cyc(1);
        check("t2_at_pulse", stage, 32'h1);
        cyc(13);
        btn_enter = 1'b0; cyc(12);
        m_enter(sw);
        check_en = 1'b1;
        cyc(2);
        check("t2_one_advance", stage, 32'h1);
        check("t2_portA", portA, 32'h06);

        // Reset during a held ENTER in S_READY.
        press(6'b000001, 1, 0);
        press(6'b000001, 1, 0);
        check("t6_ready", stage, 32'h3);
        check_en = 1'b0;
        sw = 6'b000010;
        btn_enter = 1'b1; cyc(3);
        rst = 1'b1; cyc(1);
        check("t6_reset_now", {12'h0, portA, portB, MODE, stage, valid, mode_err}, 32'h0);
        rst = 1'b0;
        m_reset();
        cyc(20);
        check("t6_stage_after", stage, 32'h1);
        check("t6_portA", portA, 32'h02);
        btn_enter = 1'b0; cyc(12);
        m_enter(sw);
        check_en = 1'b1;
        cyc(3);
        check("t6_single_pulse", stage, 32'h1);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
